// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the register-file write scheduler.
//   ADDR_W    : default register-address width
//   regaddr_t : register address type for the default width
//   XZR       : architectural index of the hardwired zero register
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int ADDR_W = 5;

    typedef logic [ADDR_W-1:0] regaddr_t;

    localparam int XZR = 31;

endpackage : regfile_pkg

// File: rtl/onehot_dec.sv
// -----------------------------------------------------------------------------
// onehot_dec
// Combinational ADDR_W-to-2**ADDR_W one-hot decoder with enable.
// Ports:
//   en_i   in  1        decode enable; all outputs 0 when low
//   addr_i in  ADDR_W   index to decode
//   dec_o  out NOUT     one-hot result (at most one bit set)
// -----------------------------------------------------------------------------
module onehot_dec #(
    parameter int ADDR_W = 5,
    parameter int NOUT   = 2**ADDR_W
) (
    input  logic              en_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [NOUT-1:0]   dec_o
);
    import regfile_pkg::*;

    genvar gi;
    generate
        for (gi = 0; gi < NOUT; gi++) begin : g_bit
            assign dec_o[gi] = en_i && (addr_i == ADDR_W'(gi));
        end
    endgenerate

endmodule : onehot_dec

// File: rtl/regfile_wr_sched.sv
// -----------------------------------------------------------------------------
// regfile_wr_sched
// Writeback address decoder plus per-register pending-write scoreboard.
// Produces registered one-hot write enables for the register array and
// tracks which registers have an issued-but-not-written-back result, for
// RAW (busy_a/busy_b) and WAW (issue_ready) hazard detection.
//
// Ports:
//   clk          in   1         clock, rising edge
//   reset_n      in   1         asynchronous active-low reset
//   issue_valid  in   1         issuing instruction has a destination
//   issue_addr   in   ADDR_W    destination of the issuing instruction
//   issue_ready  out  1         issue may be accepted (combinational)
//   wb_valid     in   1         writeback this cycle
//   wb_addr      in   ADDR_W    writeback destination
//   wr_en        out  NREG      registered one-hot write enables
//   rd_addr_a/b  in   ADDR_W    source lookup addresses
//   busy_a/b     out  1         source has a pending write (combinational)
//   flush        in   1         synchronous clear of all pending bits
//   pending_cnt  out  ADDR_W+1  popcount of busy bits (registered)
//   wb_err       out  1         one-cycle pulse: writeback to non-busy reg
//
// Compile-time option: REGFILE_ZERO_REG_EN makes ZERO_REG a hardwired zero
// register (never busy, never written, never flagged).
// -----------------------------------------------------------------------------
module regfile_wr_sched #(
    parameter int ADDR_W   = regfile_pkg::ADDR_W,
    parameter int NREG     = 2**ADDR_W,
    parameter int ZERO_REG = NREG - 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              issue_ready,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    output logic [NREG-1:0]   wr_en,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic              busy_a,
    output logic              busy_b,
    input  logic              flush,
    output logic [ADDR_W:0]   pending_cnt,
    output logic              wb_err
);
    import regfile_pkg::*;

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    // Constant-folds to 0 when the zero-register option is off.
    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return ZERO_EN && (a == ADDR_W'(ZERO_REG));
    endfunction

    logic [NREG-1:0] busy_q, busy_d;
    logic [NREG-1:0] wr_en_q, wr_en_d;
    logic [ADDR_W:0] cnt_q, cnt_d;
    logic            wb_err_q, wb_err_d;

    logic            issue_zero, wb_zero;
    logic            issue_acc, wb_act;
    logic [NREG-1:0] issue_mask, wb_mask;

    assign issue_zero = is_zero(issue_addr);
    assign wb_zero    = is_zero(wb_addr);

    // WAW stall, bypassed when the pending write retires this very cycle.
    assign issue_ready = !busy_q[issue_addr]
                      || (wb_valid && (wb_addr == issue_addr))
                      || issue_zero;

    // A flush squashes the issuing instruction even though it saw ready.
    assign issue_acc = issue_valid && issue_ready && !flush && !issue_zero;
    assign wb_act    = wb_valid && !wb_zero;

    onehot_dec #(.ADDR_W(ADDR_W), .NOUT(NREG)) u_issue_dec (
        .en_i   (issue_acc),
        .addr_i (issue_addr),
        .dec_o  (issue_mask)
    );

    onehot_dec #(.ADDR_W(ADDR_W), .NOUT(NREG)) u_wb_dec (
        .en_i   (wb_act),
        .addr_i (wb_addr),
        .dec_o  (wb_mask)
    );

    // Set beats clear, so a same-cycle issue+wb to one register stays busy.
    always_comb begin
        busy_d   = flush ? '0 : ((busy_q & ~wb_mask) | issue_mask);
        wr_en_d  = wb_mask;
        wb_err_d = wb_act && !flush && !busy_q[wb_addr];
        cnt_d    = '0;
        for (int i = 0; i < NREG; i++) begin
            cnt_d = cnt_d + {{ADDR_W{1'b0}}, busy_d[i]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q   <= '0;
            wr_en_q  <= '0;
            cnt_q    <= '0;
            wb_err_q <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            wr_en_q  <= wr_en_d;
            cnt_q    <= cnt_d;
            wb_err_q <= wb_err_d;
        end
    end

    // Lookups see current state only; same-cycle writebacks are forwarded
    // elsewhere in the pipeline.
    assign busy_a = busy_q[rd_addr_a] && !is_zero(rd_addr_a);
    assign busy_b = busy_q[rd_addr_b] && !is_zero(rd_addr_b);

    assign wr_en       = wr_en_q;
    assign pending_cnt = cnt_q;
    assign wb_err      = wb_err_q;

endmodule : regfile_wr_sched

// File: tb/tb_regfile_wr_sched.sv
module tb_regfile_wr_sched;

    localparam int AW = 5;
    localparam int NR = 32;
`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZEN = 1'b1;
`else
    localparam bit ZEN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          issue_valid;
    logic [AW-1:0] issue_addr;
    logic          issue_ready;
    logic          wb_valid;
    logic [AW-1:0] wb_addr;
    logic [NR-1:0] wr_en;
    logic [AW-1:0] rd_addr_a, rd_addr_b;
    logic          busy_a, busy_b;
    logic          flush;
    logic [AW:0]   pending_cnt;
    logic          wb_err;

    int checks = 0;
    int errors = 0;

    // Reference model: set of pending registers plus expected registered outputs.
    bit            m_busy [NR];
    logic [NR-1:0] m_wr_en;
    logic          m_err;
    int            m_cnt;

    regfile_wr_sched dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .issue_ready (issue_ready),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wr_en       (wr_en),
        .rd_addr_a   (rd_addr_a),
        .rd_addr_b   (rd_addr_b),
        .busy_a      (busy_a),
        .busy_b      (busy_b),
        .flush       (flush),
        .pending_cnt (pending_cnt),
        .wb_err      (wb_err)
    );

    always #5 clk = ~clk;

    function automatic bit m_is_zero(input int a);
        return ZEN && (a == NR - 1);
    endfunction

    function automatic bit m_ready(input int a);
        if (m_is_zero(a)) return 1'b1;
        if (!m_busy[a]) return 1'b1;
        return wb_valid && (int'(wb_addr) == a);
    endfunction

    function automatic bit m_lookup(input int a);
        return m_busy[a] && !m_is_zero(a);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
        m_wr_en = '0;
        m_err   = 1'b0;
        m_cnt   = 0;
    endtask

    // Apply the scoreboard rules to the inputs present before the edge.
    task automatic model_clock();
        bit acc;
        int wa, ia;
        wa  = int'(wb_addr);
        ia  = int'(issue_addr);
        acc = issue_valid && m_ready(ia) && !flush && !m_is_zero(ia);
        m_wr_en = '0;
        if (wb_valid && !m_is_zero(wa)) m_wr_en[wa] = 1'b1;
        m_err = wb_valid && !flush && !m_busy[wa] && !m_is_zero(wa);
        if (flush) begin
            for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
        end else begin
            if (wb_valid) m_busy[wa] = 1'b0;
            if (acc) m_busy[ia] = 1'b1;
        end
        m_cnt = 0;
        for (int i = 0; i < NR; i++) m_cnt += int'(m_busy[i]);
    endtask

    task automatic step();
        model_clock();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0; issue_addr = '0;
        wb_valid = 1'b0; wb_addr = '0;
        flush = 1'b0; rd_addr_a = '0; rd_addr_b = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (wr_en !== '0) begin errors++; $display("FAIL reset_wr_en got %h exp 0", wr_en); end
        checks++; if (pending_cnt !== '0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", pending_cnt); end
        checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL reset_wb_err got %b exp 0", wb_err); end
        checks++; if (busy_a !== 1'b0 || issue_ready !== 1'b1) begin errors++; $display("FAIL reset_comb busy_a %b ready %b exp 0/1", busy_a, issue_ready); end
        $display("reset: wr_en=%h cnt=%0d err=%b", wr_en, pending_cnt, wb_err);
    endtask

    task automatic test_wb_no_issue();
        idle_inputs();
        wb_valid = 1'b1; wb_addr = 5'd5;
        step();
        idle_inputs();
        checks++; if (wr_en !== 32'h0000_0020) begin errors++; $display("FAIL wb_err_wr_en got %h exp 00000020", wr_en); end
        checks++; if (wb_err !== 1'b1) begin errors++; $display("FAIL wb_err_pulse got %b exp 1", wb_err); end
        step();
        checks++; if (wr_en !== '0 || wb_err !== 1'b0) begin errors++; $display("FAIL wb_err_clear got wr_en %h err %b exp 0/0", wr_en, wb_err); end
        $display("wb_no_issue: wb 5 -> err pulse then clear");
    endtask

    task automatic test_waw();
        idle_inputs();
        issue_valid = 1'b1; issue_addr = 5'd3;
        step();
        rd_addr_a = 5'd3;
        #1;
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL waw_stall got ready %b exp 0", issue_ready); end
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL waw_busy_a got %b exp 1", busy_a); end
        step();
        wb_valid = 1'b1; wb_addr = 5'd3;
        #1;
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL waw_bypass got ready %b exp 1", issue_ready); end
        step();
        idle_inputs(); rd_addr_a = 5'd3;
        #1;
        checks++; if (wr_en !== 32'h0000_0008) begin errors++; $display("FAIL waw_wr_en got %h exp 00000008", wr_en); end
        checks++; if (busy_a !== 1'b1 || pending_cnt !== 6'd1) begin errors++; $display("FAIL waw_hold busy_a %b cnt %0d exp 1/1", busy_a, pending_cnt); end
        checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL waw_err got %b exp 0", wb_err); end
        wb_valid = 1'b1; wb_addr = 5'd3;
        step();
        idle_inputs();
        $display("waw: issue 3 stalled, bypassed by wb 3, cnt=%0d", pending_cnt);
    endtask

    task automatic test_flush();
        idle_inputs();
        issue_valid = 1'b1;
        issue_addr = 5'd1; step();
        issue_addr = 5'd2; step();
        issue_addr = 5'd4; step();
        idle_inputs();
        checks++; if (pending_cnt !== 6'd3) begin errors++; $display("FAIL flush_pre_cnt got %0d exp 3", pending_cnt); end
        flush = 1'b1; wb_valid = 1'b1; wb_addr = 5'd2;
        issue_valid = 1'b1; issue_addr = 5'd9;
        step();
        idle_inputs(); rd_addr_a = 5'd1; rd_addr_b = 5'd9;
        #1;
        checks++; if (pending_cnt !== '0) begin errors++; $display("FAIL flush_cnt got %0d exp 0", pending_cnt); end
        checks++; if (wr_en !== 32'h0000_0004) begin errors++; $display("FAIL flush_wr_en got %h exp 00000004", wr_en); end
        checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL flush_err got %b exp 0", wb_err); end
        checks++; if (busy_a !== 1'b0 || busy_b !== 1'b0) begin errors++; $display("FAIL flush_busy got %b%b exp 00", busy_a, busy_b); end
        $display("flush: cnt=%0d wr_en=%h", pending_cnt, wr_en);
    endtask

    task automatic test_zero_reg();
        idle_inputs();
        issue_valid = 1'b1; issue_addr = 5'd31;
        step();
        idle_inputs(); rd_addr_b = 5'd31;
        #1;
        checks++; if (busy_b !== (ZEN ? 1'b0 : 1'b1)) begin errors++; $display("FAIL zero_busy_b got %b exp %b", busy_b, !ZEN); end
        wb_valid = 1'b1; wb_addr = 5'd31;
        step();
        idle_inputs();
        checks++; if (wr_en !== (ZEN ? 32'h0 : 32'h8000_0000)) begin errors++; $display("FAIL zero_wr_en got %h", wr_en); end
        checks++; if (pending_cnt !== '0 || wb_err !== 1'b0) begin errors++; $display("FAIL zero_state cnt %0d err %b exp 0/0", pending_cnt, wb_err); end
        $display("zero_reg: zen=%b wr_en=%h", ZEN, wr_en);
    endtask

    task automatic test_async_reset();
        idle_inputs();
        issue_valid = 1'b1; issue_addr = 5'd7;
        wb_valid = 1'b1; wb_addr = 5'd9;
        step();
        idle_inputs(); rd_addr_a = 5'd7;
        #1;
        checks++; if (busy_a !== 1'b1 || wr_en !== 32'h0000_0200) begin errors++; $display("FAIL areset_pre busy %b wr_en %h", busy_a, wr_en); end
        #1 reset_n = 1'b0;
        model_reset();
        #1;
        checks++; if (busy_a !== 1'b0 || pending_cnt !== '0 || wr_en !== '0 || wb_err !== 1'b0) begin
            errors++; $display("FAIL areset_clear busy %b cnt %0d wr_en %h err %b", busy_a, pending_cnt, wr_en, wb_err);
        end
        @(negedge clk);
        reset_n = 1'b1;
        issue_valid = 1'b1; issue_addr = 5'd7;
        #1;
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL areset_ready got %b exp 1", issue_ready); end
        idle_inputs();
        $display("async_reset: state cleared without clock edge");
    endtask

    task automatic test_sweep();
        logic [NR-1:0] exp;
        idle_inputs();
        for (int a = 0; a < NR; a++) begin
            wb_valid = 1'b1; wb_addr = AW'(a);
            step();
            exp = '0;
            if (!m_is_zero(a)) exp[a] = 1'b1;
            checks++; if (wr_en !== exp) begin errors++; $display("FAIL sweep_on addr %0d got %h exp %h", a, wr_en, exp); end
        end
        for (int a = 0; a < NR; a++) begin
            wb_valid = 1'b0; wb_addr = AW'(a);
            step();
            checks++; if (wr_en !== '0) begin errors++; $display("FAIL sweep_off addr %0d got %h exp 0", a, wr_en); end
        end
        idle_inputs();
        $display("sweep: 64 decode cycles checked");
    endtask

    task automatic test_random();
        for (int n = 0; n < 500; n++) begin
            issue_valid = ($urandom_range(0, 3) != 0);
            issue_addr  = AW'($urandom_range(0, 7) == 0 ? 31 : $urandom_range(0, 11));
            wb_valid    = ($urandom_range(0, 1) != 0);
            wb_addr     = AW'($urandom_range(0, 7) == 0 ? 31 : $urandom_range(0, 11));
            flush       = ($urandom_range(0, 31) == 0);
            rd_addr_a   = AW'($urandom_range(0, 11));
            rd_addr_b   = AW'($urandom_range(0, 7) == 0 ? 31 : $urandom_range(0, 11));
            #1;
            checks++; if (issue_ready !== m_ready(int'(issue_addr))) begin errors++; $display("FAIL rnd_ready cyc %0d addr %0d got %b exp %b", n, issue_addr, issue_ready, m_ready(int'(issue_addr))); end
            checks++; if (busy_a !== m_lookup(int'(rd_addr_a)) || busy_b !== m_lookup(int'(rd_addr_b))) begin
                errors++; $display("FAIL rnd_busy cyc %0d got %b%b exp %b%b", n, busy_a, busy_b, m_lookup(int'(rd_addr_a)), m_lookup(int'(rd_addr_b)));
            end
            step();
            checks++; if (wr_en !== m_wr_en || wb_err !== m_err || int'(pending_cnt) != m_cnt) begin
                errors++; $display("FAIL rnd_regs cyc %0d wr_en %h/%h err %b/%b cnt %0d/%0d", n, wr_en, m_wr_en, wb_err, m_err, pending_cnt, m_cnt);
            end
        end
        idle_inputs();
        $display("random: 500 cycles against reference model");
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        model_reset();
        @(negedge clk);
        test_reset();
        test_wb_no_issue();
        test_waw();
        test_flush();
        test_zero_reg();
        test_async_reset();
        test_sweep();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_regfile_wr_sched

// File: doc/regfile_wr_sched.md
Name: regfile_wr_sched

Overview:
- Parametrised successor to the register-file write-address decoder.
- Decodes the writeback address into a registered one-hot write-enable vector for the register array.
- Also keeps a per-register pending-write scoreboard, used by the pipeline for RAW and WAW hazard detection.
- Sits between decode/issue, writeback and the register array.

Parameters:
- ADDR_W, 5, register-address width.
- NREG, 2**ADDR_W, number of registers; must equal 2**ADDR_W.
- ZERO_REG, NREG-1, index of the hardwired zero register; used only when the optional feature is compiled in.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  instruction with a destination register requests issue.
- issue_addr  in  ADDR_W  destination register of the issuing instruction.
- issue_ready  out  1  issue may be accepted this cycle (combinational).
- wb_valid  in  1  writeback this cycle.
- wb_addr  in  ADDR_W  writeback destination.
- wr_en  out  NREG  registered one-hot write enables to the register array.
- rd_addr_a  in  ADDR_W  source A lookup address.
- rd_addr_b  in  ADDR_W  source B lookup address.
- busy_a  out  1  source A has a pending write (combinational).
- busy_b  out  1  source B has a pending write (combinational).
- flush  in  1  synchronous clear of all pending bits (squash).
- pending_cnt  out  ADDR_W+1  number of set busy bits (registered).
- wb_err  out  1  registered one-cycle pulse: writeback to a non-busy register.

Behaviour:
- Reset (reset_n low, asynchronous):
  - all busy bits = 0, wr_en = 0, pending_cnt = 0, wb_err = 0.
  - Combinational outputs follow from these cleared bits.
- Write decode:
  - wr_en is a one-hot decode of wb_addr when wb_valid = 1, otherwise all zero.
  - Registered, latency 1 cycle.
  - Never more than one bit set.
- Scoreboard, per register r, next state with priority high to low:
  - flush: busy[r] = 0.
  - accepted issue to r: busy[r] = 1.
  - wb to r: busy[r] = 0.
  - otherwise: hold.
- Acceptance and ready:
  - An issue is accepted when issue_valid && issue_ready.
  - issue_ready = !busy[issue_addr] || (wb_valid && wb_addr == issue_addr). This is a WAW stall with same-cycle writeback bypass.
  - issue_ready is independent of issue_valid.
- Same-cycle issue and wb to the same register:
  - issue is accepted and busy stays 1.
  - wr_en is still produced for the wb.
- Flush:
  - busy vector is 0 next cycle.
  - A same-cycle wb still produces wr_en; a same-cycle issue is dropped.
  - pending_cnt is 0 next cycle.
- Lookups: busy_a = busy[rd_addr_a] and busy_b = busy[rd_addr_b], from the current state only. There is no bypass of a same-cycle wb; forwarding handles that case.
- wb_err:
  - Pulses for one cycle after a wb to a register whose busy bit was 0, with no flush in that cycle.
  - wr_en is still asserted in that case.
- pending_cnt equals the popcount of the next busy vector and is registered alongside it.
- Reset mid-operation: all state is cleared immediately, and any in-flight wr_en is dropped.

Optional Feature:
- Macro REGFILE_ZERO_REG_EN.
- When defined:
  - An issue to ZERO_REG is always ready and never sets a busy bit.
  - A wb to ZERO_REG produces no wr_en bit and no wb_err.
  - busy_a and busy_b read 0 for ZERO_REG.
- When undefined, ZERO_REG is an ordinary register and the parameter is unused.

Decomposition:
- Package regfile_pkg:
  - ADDR_W default constant.
  - regaddr_t typedef (logic [ADDR_W-1:0]).
  - XZR constant (31).
- One natural sub-module, onehot_dec: a parametrised ADDR_W-to-2**ADDR_W combinational decoder with enable. It is used for wr_en generation and for the issue and wb set/clear masks.

Test Plan:
- Reset, then wb_valid = 1, wb_addr = 5 with no prior issue -> next cycle wr_en = 32'h0000_0020 and wb_err = 1; cycle after, wr_en = 0 and wb_err = 0.
- Issue addr 3, then hold issue_valid with addr 3 -> issue_ready = 0 and busy_a = 1 for rd_addr_a = 3; then wb addr 3 alongside issue addr 3 -> issue_ready = 1, busy stays 1, wr_en = 32'h8 next cycle, pending_cnt = 1.
- Issue addrs 1, 2, 4 on consecutive cycles -> pending_cnt = 3; then flush together with wb addr 2 -> pending_cnt = 0, wr_en = 32'h4, no wb_err.
- With REGFILE_ZERO_REG_EN: issue 31 then wb 31 -> busy_b (rd_addr_b = 31) = 0, wr_en stays 0, pending_cnt = 0. Without the macro: busy_b = 1 after the issue, and the wb gives wr_en = 32'h8000_0000.
- Issue addr 7, deassert reset_n mid-cycle -> busy, pending_cnt and wr_en clear without a clock edge; after release, issue addr 7 is ready.
- Sweep wb_addr 0..31 with wb_valid = 1 -> wr_en == 1 << addr each cycle (ZERO_REG excepted when the macro is defined); with wb_valid = 0, wr_en = 0 for all addresses.
